// File: rtl/timer_responder_if.sv
// Data-memory bus between the M stage (master) and a memory-mapped responder (slave).
interface timer_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_byteen, req_wdata,
        input  rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_byteen, req_wdata,
        output rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer on the M-stage data bus: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload countdown, and a maskable interrupt.
module timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic             clk,
    input  logic             reset_n,
    timer_responder_if.slave bus,
    output logic             irq
);
    localparam int unsigned DW = 32;
    localparam int unsigned BE = DW / 8;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t        state, state_nxt;
    logic          en, en_nxt;
    logic [1:0]    mode, mode_nxt;
    logic          im, im_nxt;
    logic [DW-1:0] preset, preset_nxt;
    logic [DW-1:0] count, count_nxt;
    logic          pending, pending_nxt;

    logic          hit_c, wr_ctrl_c, wr_preset_c;
    logic [DW-1:0] rd_data_c;
    logic          unused_c;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [BE-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < int'(BE); i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    assign unused_c = ^bus.req_addr[1:0];

    // Address decode and read mux (values before this edge's updates)
    always_comb begin
        hit_c       = bus.req_valid && (bus.req_addr[31:4] == BASE_ADDR[31:4]);
        wr_ctrl_c   = hit_c && bus.req_we && (bus.req_addr[3:2] == 2'd0);
        wr_preset_c = hit_c && bus.req_we && (bus.req_addr[3:2] == 2'd1);
        rd_data_c   = '0;
        case (bus.req_addr[3:2])
            2'd0:    rd_data_c = {28'd0, im, mode, en};
            2'd1:    rd_data_c = preset;
            2'd2:    rd_data_c = count;
            default: rd_data_c = '0;
        endcase
    end

    // Countdown FSM; CPU register writes are applied last so they take priority
    always_comb begin
        state_nxt   = state;
        en_nxt      = en;
        mode_nxt    = mode;
        im_nxt      = im;
        preset_nxt  = preset;
        count_nxt   = count;
        pending_nxt = pending;

        case (state)
            IDLE: begin
                if (en) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                if (preset == '0) begin
                    state_nxt   = INT;
                    pending_nxt = 1'b1;
                end else begin
                    state_nxt = CNT;
                end
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    if (count != '0) count_nxt = count - DW'(1);
                    if (count <= DW'(1)) begin
                        state_nxt   = INT;
                        pending_nxt = 1'b1;
                    end
                end
            end
            INT: begin
                if (mode == 2'b01) begin
                    pending_nxt = 1'b0;
                    state_nxt   = LOAD;
                end else begin
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (wr_preset_c) begin
            preset_nxt  = merge_bytes(preset, bus.req_wdata, bus.req_byteen);
            pending_nxt = 1'b0;
        end

        if (wr_ctrl_c) begin
            en_nxt   = en;
            mode_nxt = mode;
            im_nxt   = im;
            if (bus.req_byteen[0]) {im_nxt, mode_nxt, en_nxt} = bus.req_wdata[3:0];
            state_nxt   = IDLE;
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            en      <= 1'b0;
            mode    <= 2'b00;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            en      <= en_nxt;
            mode    <= mode_nxt;
            im      <= im_nxt;
            preset  <= preset_nxt;
            count   <= count_nxt;
            pending <= pending_nxt;
        end
    end

    // One-cycle response to every hit; stores return zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= hit_c;
            bus.rsp_rdata <= (hit_c && !bus.req_we) ? rd_data_c : '0;
        end
    end

    assign irq = im & pending;

endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder: bus decode, byte merge, one-shot, auto-reload,
// zero preset, simultaneous CTRL write, and asynchronous reset.
module tb_timer_responder;
    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV    = 32'h0000_7F0C;
    localparam logic [31:0] A_MISS   = 32'h0000_7F10;

    logic clk;
    logic reset_n;
    logic irq;
    int   n_vec;
    int   n_err;
    logic [31:0] rd;
    logic        vld;

    timer_responder_if bus ();

    timer_responder #(.BASE_ADDR(32'h0000_7F00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: request is captured at the next posedge, response sampled one negedge later
    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic v);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_byteen = be;
        bus.req_wdata  = wd;
        @(negedge clk);
        v     = bus.rsp_valid;
        rdata = bus.rsp_rdata;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic        v;
        bus_op(1'b1, addr, 4'hF, wd, d, v);
    endtask

    task automatic rdv(input logic [31:0] addr, output logic [31:0] d);
        logic v;
        bus_op(1'b0, addr, 4'h0, 32'h0, d, v);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_byteen = '0;
        bus.req_wdata  = '0;
        repeat (2) @(negedge clk);

        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        rdv(A_CTRL, rd);   chk("rst_ctrl", rd, 32'h0);
        rdv(A_PRESET, rd); chk("rst_preset", rd, 32'h0);
        rdv(A_COUNT, rd);  chk("rst_count", rd, 32'h0);

        // Bus behaviour
        bus_op(1'b1, A_PRESET, 4'hF, 32'h1234_5678, rd, vld);
        chk("st_rsp_valid", 32'(vld), 32'd1);
        chk("st_rsp_rdata", rd, 32'h0);
        bus_op(1'b1, A_PRESET, 4'b0001, 32'h0000_00AA, rd, vld);
        rdv(A_PRESET, rd); chk("be_merge", rd, 32'h1234_56AA);
        bus_op(1'b1, A_PRESET, 4'b0000, 32'hFFFF_FFFF, rd, vld);
        rdv(A_PRESET, rd); chk("be_none", rd, 32'h1234_56AA);
        wr(A_COUNT, 32'hFFFF_FFFF);
        rdv(A_COUNT, rd);  chk("count_ro", rd, 32'h0);
        wr(A_RSV, 32'hFFFF_FFFF);
        bus_op(1'b0, A_RSV, 4'h0, 32'h0, rd, vld);
        chk("rsv_valid", 32'(vld), 32'd1);
        chk("rsv_rdata", rd, 32'h0);
        bus_op(1'b0, A_MISS, 4'h0, 32'h0, rd, vld);
        chk("miss_valid", 32'(vld), 32'd0);
        wr(A_CTRL, 32'hFFFF_FFF6);
        rdv(A_CTRL, rd);   chk("ctrl_mask", rd, 32'h6);
        wr(A_CTRL, 32'h0);

        // One-shot, PRESET=3: COUNT 3,2,1,0 after edges 2..5, irq from edge 5
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 2) chk($sformatf("os_count_e%0d", k), dut.count, (k >= 5) ? 32'd0 : 32'(5 - k));
            chk($sformatf("os_irq_e%0d", k), 32'(irq), (k >= 5) ? 32'd1 : 32'd0);
        end
        rdv(A_CTRL, rd);   chk("os_ctrl_en_clr", rd, 32'h8);
        chk("os_irq_held", 32'(irq), 32'd1);
        wr(A_CTRL, 32'h8);
        chk("os_irq_drop", 32'(irq), 32'd0);

        // Auto-reload, PRESET=2: irq pulses after edges 4, 8, 12
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("ar_irq_e%0d", k), 32'(irq), (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k == 6 || k == 10) chk($sformatf("ar_reload_e%0d", k), dut.count, 32'd2);
        end
        wr(A_CTRL, 32'h0);

        // PRESET=0 with IM=0: pending after 2 edges, irq masked; then restart with IM
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("z_pending", 32'(dut.pending), 32'd1);
        chk("z_irq_masked", 32'(irq), 32'd0);
        @(negedge clk);
        chk("z_irq_after", 32'(irq), 32'd0);
        wr(A_PRESET, 32'd4);
        wr(A_CTRL, 32'h9);
        @(negedge clk);
        @(negedge clk);
        chk("z_restart_load", dut.count, 32'd4);
        @(negedge clk);
        chk("z_restart_dec", dut.count, 32'd3);
        wr(A_CTRL, 32'h0);

        // CTRL store with EN=0 lands on the edge the count reaches INT
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        repeat (4) @(negedge clk);
        wr(A_CTRL, 32'h8);
        chk("sim_pending", 32'(dut.pending), 32'd0);
        chk("sim_irq", 32'(irq), 32'd0);
        @(negedge clk);
        chk("sim_irq_next", 32'(irq), 32'd0);
        rdv(A_CTRL, rd);   chk("sim_ctrl", rd, 32'h8);

        // Asynchronous reset mid-count, while a load response is on the bus
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        repeat (2) @(negedge clk);
        bus_op(1'b0, A_PRESET, 4'h0, 32'h0, rd, vld);
        chk("pre_rst_rdata", rd, 32'd5);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rdata", bus.rsp_rdata, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rdv(A_COUNT, rd);  chk("mid_rst_count", rd, 32'h0);
        rdv(A_CTRL, rd);   chk("mid_rst_ctrl", rd, 32'h0);

        // Back-to-back requests give back-to-back responses
        wr(A_PRESET, 32'd7);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = A_PRESET;
        @(negedge clk);
        chk("b2b_valid0", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rdata0", bus.rsp_rdata, 32'd7);
        bus.req_addr  = A_RSV;
        @(negedge clk);
        chk("b2b_valid1", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rdata1", bus.rsp_rdata, 32'h0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", 32'(bus.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
